// File: rtl/zbc_iter_if.sv
// rtl/zbc_iter_if.sv - operand/result handshake bundle for the iterative carry-less multiplier
interface zbc_iter_if #(
   parameter int WIDTH = 32
) ();
   logic             Flush;
   logic             Start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [2:0]       Funct3;
   logic             Ack;
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] ZBCResult;

   modport master (
      output Flush, Start, A, B, Funct3, Ack,
      input  Busy, Done, ZBCResult
   );

   modport slave (
      input  Flush, Start, A, B, Funct3, Ack,
      output Busy, Done, ZBCResult
   );
endinterface

// File: rtl/zbc_iter.sv
// rtl/zbc_iter.sv - iterative clmul/clmulh/clmulr unit retiring STEP multiplier bits per cycle
module zbc_iter #(
   parameter int WIDTH = 32,
   parameter int STEP  = 4
) (
   input logic       clk,
   input logic       reset,
   zbc_iter_if.slave bus
);
   localparam int N  = WIDTH / STEP;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [2:0]         r_funct3;
   logic [2*WIDTH-1:0] r_p;
   logic [CW-1:0]      r_cnt;
   logic [WIDTH-1:0]   r_result;

   logic [2*WIDTH-1:0] w_p_next;
   logic [WIDTH-1:0]   w_sel;
   logic               w_accept;
   logic               w_start_go;
   logic               w_last;
   logic               w_busy;
   logic               w_done;

   assign w_accept   = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.Ack);
   assign w_start_go = w_accept && bus.Start && !bus.Flush;
   assign w_last     = (r_cnt == LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      if (bus.Flush) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (bus.Start) w_next = S_BUSY;
            S_BUSY:  if (w_last) w_next = S_DONE;
            S_DONE:  if (bus.Ack) w_next = bus.Start ? S_BUSY : S_IDLE;
            default: w_next = S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_busy = 1'b0;
      w_done = 1'b0;
      case (r_state)
         S_BUSY:  w_busy = 1'b1;
         S_DONE:  w_done = 1'b1;
         default: ;
      endcase
   end

   assign bus.Busy      = w_busy;
   assign bus.Done      = w_done;
   assign bus.ZBCResult = r_result;

   // Bit i of the shifted multiplier is absolute bit cnt*STEP+i of the original B.
   always_comb begin
      w_p_next = r_p;
      for (int i = 0; i < STEP; i++) begin
         if (r_b[i]) begin
            w_p_next = w_p_next ^ ({{WIDTH{1'b0}}, r_a} << (int'(r_cnt) * STEP + i));
         end
      end
   end

   always_comb begin
      case (r_funct3)
         3'b001:  w_sel = w_p_next[WIDTH-1:0];
         3'b011:  w_sel = w_p_next[2*WIDTH-1:WIDTH];
         3'b010:  w_sel = w_p_next[2*WIDTH-2:WIDTH-1];
         default: w_sel = '0;
      endcase
   end

   // A flushed operation must never reach r_result, so the busy update is gated by Flush.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_a      <= '0;
         r_b      <= '0;
         r_funct3 <= '0;
         r_p      <= '0;
         r_cnt    <= '0;
         r_result <= '0;
      end else if (w_start_go) begin
         r_a      <= bus.A;
         r_b      <= bus.B;
         r_funct3 <= bus.Funct3;
         r_p      <= '0;
         r_cnt    <= '0;
      end else if (w_busy && !bus.Flush) begin
         r_p <= w_p_next;
         r_b <= r_b >> STEP;
         if (w_last) begin
            r_result <= w_sel;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end
endmodule

// File: tb/tb_zbc_iter.sv
// tb/tb_zbc_iter.sv - directed scoreboard bench for zbc_iter
module tb_zbc_iter;
   localparam int WIDTH = 32;
   localparam int STEP  = 4;
   localparam int N     = WIDTH / STEP;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   zbc_iter_if #(.WIDTH(WIDTH)) bus_if ();

   zbc_iter #(.WIDTH(WIDTH), .STEP(STEP)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   int          vectors     = 0;
   int          miscompares = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_zbc(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] f);
      logic [63:0] p;
      p = '0;
      for (int i = 0; i < 32; i++) if (b[i]) p = p ^ ({32'b0, a} << i);
      case (f)
         3'b001:  return p[31:0];
         3'b011:  return p[63:32];
         3'b010:  return p[62:31];
         default: return 32'h0;
      endcase
   endfunction

   // Leaves the bench at the falling edge of the first busy cycle.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                        input bit push, input logic [31:0] exp);
      @(negedge clk);
      bus_if.A      = a;
      bus_if.B      = b;
      bus_if.Funct3 = f;
      bus_if.Start  = 1'b1;
      if (push) exp_q.push_back(exp);
      @(negedge clk);
      bus_if.Start  = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int exp_busy);
      int nb;
      bit seen;
      nb   = 0;
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (bus_if.Done) begin
            seen = 1'b1;
            break;
         end
         if (bus_if.Busy) nb++;
         @(negedge clk);
      end
      check({tag, "_done"}, 64'(seen), 64'd1);
      check({tag, "_busy_cycles"}, 64'(nb), 64'(exp_busy));
      if (seen) begin
         if (exp_q.size() == 0) check({tag, "_queue"}, 64'd0, 64'd1);
         else check({tag, "_result"}, 64'(bus_if.ZBCResult), 64'(exp_q.pop_front()));
      end
   endtask

   task automatic ack_idle(input string tag);
      bus_if.Ack = 1'b1;
      @(negedge clk);
      bus_if.Ack = 1'b0;
      check({tag, "_ack_done"}, 64'(bus_if.Done), 64'd0);
      check({tag, "_ack_busy"}, 64'(bus_if.Busy), 64'd0);
   endtask

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f, input logic [31:0] exp);
      issue(a, b, f, 1'b1, exp);
      wait_done(tag, N);
      ack_idle(tag);
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic [2:0]  rf;
      int          dcount;

      reset         = 1'b1;
      bus_if.Flush  = 1'b0;
      bus_if.Start  = 1'b0;
      bus_if.Ack    = 1'b0;
      bus_if.A      = '0;
      bus_if.B      = '0;
      bus_if.Funct3 = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(bus_if.Busy), 64'd0);
      check("rst_done", 64'(bus_if.Done), 64'd0);
      check("rst_result", 64'(bus_if.ZBCResult), 64'd0);
      reset = 1'b0;

      run_op("clmul_3x3", 32'h3, 32'h3, 3'b001, 32'h0000_0005);
      run_op("clmulh_msb", 32'h8000_0000, 32'h8000_0000, 3'b011, 32'h4000_0000);
      run_op("clmulr_msb", 32'h8000_0000, 32'h8000_0000, 3'b010, 32'h8000_0000);
      run_op("clmul_msb", 32'h8000_0000, 32'h8000_0000, 3'b001, 32'h0000_0000);
      run_op("clmul_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b001, 32'h5555_5555);
      run_op("clmulh_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b011, 32'h5555_5555);
      run_op("invalid_f3", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b000, 32'h0000_0000);

      for (int r = 0; r < 4; r++) begin
         ra = $urandom;
         rb = $urandom;
         rf = (r % 3 == 0) ? 3'b001 : ((r % 3 == 1) ? 3'b011 : 3'b010);
         run_op("random", ra, rb, rf, ref_zbc(ra, rb, rf));
      end

      // Start during BUSY is ignored; result of 5 clmul 7 is 0x1B.
      issue(32'h5, 32'h7, 3'b001, 1'b1, 32'h0000_001B);
      @(negedge clk);
      bus_if.A      = 32'hFFFF_FFFF;
      bus_if.B      = 32'hFFFF_FFFF;
      bus_if.Start  = 1'b1;
      @(negedge clk);
      bus_if.Start  = 1'b0;
      wait_done("busy_start", N - 2);
      for (int h = 0; h < 5; h++) begin
         @(negedge clk);
         check("hold_done", 64'(bus_if.Done), 64'd1);
         check("hold_result", 64'(bus_if.ZBCResult), 64'h1B);
      end

      // Ack together with Start goes straight back to BUSY.
      bus_if.A      = 32'h3;
      bus_if.B      = 32'h3;
      bus_if.Funct3 = 3'b001;
      bus_if.Start  = 1'b1;
      bus_if.Ack    = 1'b1;
      exp_q.push_back(32'h0000_0005);
      @(negedge clk);
      bus_if.Start  = 1'b0;
      bus_if.Ack    = 1'b0;
      check("b2b_busy", 64'(bus_if.Busy), 64'd1);
      check("b2b_done", 64'(bus_if.Done), 64'd0);
      wait_done("b2b", N);
      ack_idle("b2b");

      // Flush on the fourth busy cycle.
      issue(32'hF, 32'hF, 3'b001, 1'b0, 32'h0);
      repeat (3) @(negedge clk);
      check("flush_pre_busy", 64'(bus_if.Busy), 64'd1);
      bus_if.Flush = 1'b1;
      @(negedge clk);
      bus_if.Flush = 1'b0;
      check("flush_busy", 64'(bus_if.Busy), 64'd0);
      check("flush_done", 64'(bus_if.Done), 64'd0);
      dcount = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (bus_if.Done) dcount++;
      end
      check("flush_no_done", 64'(dcount), 64'd0);
      check("flush_result_kept", 64'(bus_if.ZBCResult), 64'h5);

      bus_if.Start = 1'b1;
      bus_if.Flush = 1'b1;
      @(negedge clk);
      bus_if.Start = 1'b0;
      bus_if.Flush = 1'b0;
      check("flush_start_busy", 64'(bus_if.Busy), 64'd0);
      check("flush_start_done", 64'(bus_if.Done), 64'd0);

      // Reset while BUSY.
      issue(32'h3, 32'h3, 3'b001, 1'b0, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst_busy_busy", 64'(bus_if.Busy), 64'd0);
      check("rst_busy_done", 64'(bus_if.Done), 64'd0);
      check("rst_busy_result", 64'(bus_if.ZBCResult), 64'd0);

      // Reset while DONE.
      issue(32'hF, 32'hF, 3'b001, 1'b1, 32'h0000_0055);
      wait_done("pre_rst_done", N);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst_done_busy", 64'(bus_if.Busy), 64'd0);
      check("rst_done_done", 64'(bus_if.Done), 64'd0);
      check("rst_done_result", 64'(bus_if.ZBCResult), 64'd0);

      run_op("post_rst", 32'h3, 32'h3, 3'b001, 32'h0000_0005);
      check("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
